i2c_burst_ctrl: RTL and testbench

I2C_BURST_CTRL -- requirements
Module: i2c_burst_ctrl

---
 rtl/i2c_ctrl_pkg.sv | 22 ++
 rtl/i2c_burst_ctrl.sv | 164 ++++++++++++++++
 tb/tb_i2c_burst_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_ctrl_pkg.sv
// Shared definitions for the I2C burst controller: FSM state encoding,
// default tuning constants and the chunk-length helper.
package i2c_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } ctrl_state_e;

  localparam int unsigned DefMaxChunk   = 16;
  localparam int unsigned DefMaxRetry   = 7;
  localparam int unsigned DefWdogCycles = 4095;

  // Length field (bytes minus 1) of the next chunk given the bytes still owed.
  function automatic logic [7:0] chunk_len(input logic [8:0] rem, input logic [8:0] max_chunk);
    logic [8:0] n;
    n = (rem > max_chunk) ? max_chunk : rem;
    return 8'(n - 9'd1);
  endfunction

endpackage

// File: rtl/i2c_burst_ctrl.sv
// Splits a burst request of up to 256 bytes into I2C transactions of at most
// MAX_CHUNK bytes, re-issuing a chunk on engine failure or watchdog timeout
// up to MAX_RETRY times before aborting the burst. All outputs are registered.
module i2c_burst_ctrl
  import i2c_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CHUNK   = DefMaxChunk,
  parameter int unsigned MAX_RETRY   = DefMaxRetry,
  parameter int unsigned WDOG_CYCLES = DefWdogCycles
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        burst_req_vld,
  input  logic [1:0]  burst_cmd,
  input  logic [19:0] burst_address,
  input  logic [7:0]  burst_len,
  input  logic        i2c_fsm_complete,
  input  logic        i2c_fsm_failed,
  output logic        de_mux_i2c_tr_vld,
  output logic [1:0]  de_mux_i2c_cmd,
  output logic [19:0] de_mux_i2c_address,
  output logic [7:0]  de_mux_i2c_len,
  output logic        burst_busy,
  output logic        burst_done,
  output logic        burst_failed,
  output logic [2:0]  burst_retry_cnt
);

  localparam int unsigned      WdogW    = $clog2(WDOG_CYCLES + 1);
  localparam logic [8:0]       ChunkMax = 9'(MAX_CHUNK);
  localparam logic [2:0]       RetryMax = 3'(MAX_RETRY);
  // Watchdog fires in the WDOG_CYCLES-th WAIT cycle counted from the issue cycle.
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

  ctrl_state_e      state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [19:0]      addr_q, addr_d;
  logic [8:0]       rem_q, rem_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic [2:0]       retry_q, retry_d;
  logic             tr_vld_q, tr_vld_d;
  logic [1:0]       out_cmd_q, out_cmd_d;
  logic [19:0]      out_addr_q, out_addr_d;
  logic [7:0]       out_len_q, out_len_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             failed_q, failed_d;

  logic             chunk_fail;
  logic [8:0]       rem_after;

  // Next-state and output-register decode.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    wdog_d     = wdog_q;
    retry_d    = retry_q;
    tr_vld_d   = 1'b0;
    out_cmd_d  = out_cmd_q;
    out_addr_d = out_addr_q;
    out_len_d  = out_len_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    failed_d   = 1'b0;
    // Failure wins over a simultaneous complete.
    chunk_fail = i2c_fsm_failed || (wdog_q == WdogLast);
    rem_after  = rem_q - (9'(out_len_q) + 9'd1);

    unique case (state_q)
      StIdle: begin
        if (burst_req_vld) begin
          cmd_d   = burst_cmd;
          addr_d  = burst_address;
          rem_d   = 9'(burst_len) + 9'd1;
          retry_d = 3'd0;
          busy_d  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        tr_vld_d   = 1'b1;
        out_cmd_d  = cmd_q;
        out_addr_d = addr_q;
        out_len_d  = chunk_len(rem_q, ChunkMax);
        wdog_d     = '0;
        state_d    = StWait;
      end
      StWait: begin
        wdog_d = wdog_q + 1'b1;
        // Follow-on issues are launched straight from the response edge so the
        // next chunk leaves one cycle after the pulse.
        if (chunk_fail) begin
          wdog_d = '0;
          if (retry_q < RetryMax) begin
            retry_d  = retry_q + 3'd1;
            tr_vld_d = 1'b1;
          end else begin
            failed_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = StIdle;
          end
        end else if (i2c_fsm_complete) begin
          rem_d   = rem_after;
          retry_d = 3'd0;
          wdog_d  = '0;
          if (rem_after != 9'd0) begin
            tr_vld_d  = 1'b1;
            out_len_d = chunk_len(rem_after, ChunkMax);
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset clears everything without pulsing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      wdog_q     <= '0;
      retry_q    <= '0;
      tr_vld_q   <= 1'b0;
      out_cmd_q  <= '0;
      out_addr_q <= '0;
      out_len_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      failed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wdog_q     <= wdog_d;
      retry_q    <= retry_d;
      tr_vld_q   <= tr_vld_d;
      out_cmd_q  <= out_cmd_d;
      out_addr_q <= out_addr_d;
      out_len_q  <= out_len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      failed_q   <= failed_d;
    end
  end

  assign de_mux_i2c_tr_vld  = tr_vld_q;
  assign de_mux_i2c_cmd     = out_cmd_q;
  assign de_mux_i2c_address = out_addr_q;
  assign de_mux_i2c_len     = out_len_q;
  assign burst_busy         = busy_q;
  assign burst_done         = done_q;
  assign burst_failed       = failed_q;
  assign burst_retry_cnt    = retry_q;

endmodule

// File: tb/tb_i2c_burst_ctrl.sv
// Directed bench for i2c_burst_ctrl with default parameters. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_i2c_burst_ctrl;

  logic        clk;
  logic        rst_n;
  logic        burst_req_vld;
  logic [1:0]  burst_cmd;
  logic [19:0] burst_address;
  logic [7:0]  burst_len;
  logic        i2c_fsm_complete;
  logic        i2c_fsm_failed;
  logic        de_mux_i2c_tr_vld;
  logic [1:0]  de_mux_i2c_cmd;
  logic [19:0] de_mux_i2c_address;
  logic [7:0]  de_mux_i2c_len;
  logic        burst_busy;
  logic        burst_done;
  logic        burst_failed;
  logic [2:0]  burst_retry_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int issue_cnt = 0;
  int done_cnt  = 0;
  int fail_cnt  = 0;

  i2c_burst_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .burst_req_vld      (burst_req_vld),
    .burst_cmd          (burst_cmd),
    .burst_address      (burst_address),
    .burst_len          (burst_len),
    .i2c_fsm_complete   (i2c_fsm_complete),
    .i2c_fsm_failed     (i2c_fsm_failed),
    .de_mux_i2c_tr_vld  (de_mux_i2c_tr_vld),
    .de_mux_i2c_cmd     (de_mux_i2c_cmd),
    .de_mux_i2c_address (de_mux_i2c_address),
    .de_mux_i2c_len     (de_mux_i2c_len),
    .burst_busy         (burst_busy),
    .burst_done         (burst_done),
    .burst_failed       (burst_failed),
    .burst_retry_cnt    (burst_retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (de_mux_i2c_tr_vld === 1'b1) issue_cnt++;
    if (burst_done === 1'b1) done_cnt++;
    if (burst_failed === 1'b1) fail_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive a one-cycle request; returns on the falling edge of the next cycle.
  task automatic req_burst(input logic [7:0] len, input logic [1:0] cmd, input logic [19:0] addr);
    burst_req_vld = 1'b1;
    burst_len     = len;
    burst_cmd     = cmd;
    burst_address = addr;
    @(negedge clk);
    burst_req_vld = 1'b0;
  endtask

  // Cycles from the current one until tr_vld is seen (0 = already high).
  task automatic wait_issue(output int lat);
    lat = 0;
    while (de_mux_i2c_tr_vld !== 1'b1 && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One-cycle engine response; returns on the falling edge of the next cycle.
  task automatic respond(input logic c, input logic f);
    i2c_fsm_complete = c;
    i2c_fsm_failed   = f;
    @(negedge clk);
    i2c_fsm_complete = 1'b0;
    i2c_fsm_failed   = 1'b0;
  endtask

  function automatic logic [36:0] all_outs();
    return {de_mux_i2c_tr_vld, de_mux_i2c_cmd, de_mux_i2c_address, de_mux_i2c_len,
            burst_busy, burst_done, burst_failed, burst_retry_cnt};
  endfunction

  initial begin
    int lat;
    int base;
    rst_n            = 1'b0;
    burst_req_vld    = 1'b0;
    burst_cmd        = 2'd0;
    burst_address    = 20'd0;
    burst_len        = 8'd0;
    i2c_fsm_complete = 1'b0;
    i2c_fsm_failed   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(all_outs()), 64'd0);

    // 40 bytes -> 16,16,8; request accepted on the first cycle out of reset.
    base  = issue_cnt;
    rst_n = 1'b1;
    req_burst(8'd39, 2'd2, 20'hABCDE);
    chk("b40_busy_rise", 64'(burst_busy), 64'd1);
    chk("b40_no_early_issue", 64'(de_mux_i2c_tr_vld), 64'd0);
    wait_issue(lat);
    chk("b40_first_lat", 64'(lat), 64'd1);
    chk("b40_len0", 64'(de_mux_i2c_len), 64'd15);
    chk("b40_cmd", 64'(de_mux_i2c_cmd), 64'd2);
    chk("b40_addr", 64'(de_mux_i2c_address), 64'hABCDE);
    @(negedge clk);
    chk("b40_vld_one_cycle", 64'(de_mux_i2c_tr_vld), 64'd0);
    chk("b40_len_held", 64'(de_mux_i2c_len), 64'd15);
    // Request while busy must be ignored.
    req_burst(8'd0, 2'd1, 20'h12345);
    respond(1'b1, 1'b0);
    wait_issue(lat);
    chk("b40_second_lat", 64'(lat), 64'd0);
    chk("b40_len1", 64'(de_mux_i2c_len), 64'd15);
    chk("b40_cmd_kept", 64'(de_mux_i2c_cmd), 64'd2);
    chk("b40_busy_mid", 64'(burst_busy), 64'd1);
    @(negedge clk);
    respond(1'b1, 1'b0);
    wait_issue(lat);
    chk("b40_third_lat", 64'(lat), 64'd0);
    chk("b40_len2", 64'(de_mux_i2c_len), 64'd7);
    chk("b40_no_done_yet", 64'(burst_done), 64'd0);
    respond(1'b1, 1'b0);
    chk("b40_done", 64'(burst_done), 64'd1);
    chk("b40_busy_drop", 64'(burst_busy), 64'd0);
    @(negedge clk);
    chk("b40_done_one_cycle", 64'(burst_done), 64'd0);
    chk("b40_len_hold_idle", 64'(de_mux_i2c_len), 64'd7);
    // Responses outside WAIT are ignored.
    respond(1'b1, 1'b1);
    @(negedge clk);
    chk("b40_issues", 64'(issue_cnt - base), 64'd3);
    chk("b40_done_cnt", 64'(done_cnt), 64'd1);
    chk("b40_fail_cnt", 64'(fail_cnt), 64'd0);

    // Single byte burst.
    base = issue_cnt;
    req_burst(8'd0, 2'd1, 20'h00042);
    wait_issue(lat);
    chk("b1_lat", 64'(lat), 64'd1);
    chk("b1_len", 64'(de_mux_i2c_len), 64'd0);
    chk("b1_addr", 64'(de_mux_i2c_address), 64'h00042);
    @(negedge clk);
    respond(1'b1, 1'b0);
    chk("b1_done", 64'(burst_done), 64'd1);
    chk("b1_issues", 64'(issue_cnt - base), 64'd1);

    // 256 bytes with two failures on the third chunk.
    base = issue_cnt;
    req_burst(8'd255, 2'd3, 20'hF0F0F);
    wait_issue(lat);
    chk("b256_lat", 64'(lat), 64'd1);
    for (int c = 0; c < 16; c++) begin
      chk("b256_len", 64'(de_mux_i2c_len), 64'd15);
      if (c == 2) begin
        for (int r = 1; r <= 2; r++) begin
          respond(1'b0, 1'b1);
          wait_issue(lat);
          chk("b256_retry_lat", 64'(lat), 64'd0);
          chk("b256_retry_len", 64'(de_mux_i2c_len), 64'd15);
          chk("b256_retry_cnt", 64'(burst_retry_cnt), 64'(r));
        end
      end
      respond(1'b1, 1'b0);
      if (c < 15) begin
        wait_issue(lat);
        chk("b256_next_lat", 64'(lat), 64'd0);
        chk("b256_retry_clr", 64'(burst_retry_cnt), 64'd0);
      end
    end
    chk("b256_done", 64'(burst_done), 64'd1);
    chk("b256_issues", 64'(issue_cnt - base), 64'd18);

    // Persistent failure: 1 issue + 7 retries, then abort.
    base = issue_cnt;
    req_burst(8'd3, 2'd0, 20'h00777);
    wait_issue(lat);
    chk("pf_lat", 64'(lat), 64'd1);
    chk("pf_len", 64'(de_mux_i2c_len), 64'd3);
    for (int r = 1; r <= 7; r++) begin
      respond(1'b0, 1'b1);
      wait_issue(lat);
      chk("pf_reissue_lat", 64'(lat), 64'd0);
    end
    chk("pf_retry7", 64'(burst_retry_cnt), 64'd7);
    respond(1'b0, 1'b1);
    chk("pf_failed", 64'(burst_failed), 64'd1);
    chk("pf_busy_drop", 64'(burst_busy), 64'd0);
    chk("pf_no_done", 64'(burst_done), 64'd0);
    @(negedge clk);
    chk("pf_issues", 64'(issue_cnt - base), 64'd8);
    chk("pf_fail_cnt", 64'(fail_cnt), 64'd1);

    // Silent engine: watchdog re-issues 4095 cycles after the issue.
    req_burst(8'd0, 2'd1, 20'h00011);
    wait_issue(lat);
    chk("wd_first_lat", 64'(lat), 64'd1);
    @(negedge clk);
    wait_issue(lat);
    chk("wd_reissue_gap", 64'(lat + 1), 64'd4095);
    chk("wd_retry1", 64'(burst_retry_cnt), 64'd1);
    // Complete and failed together count as a failure.
    @(negedge clk);
    respond(1'b1, 1'b1);
    wait_issue(lat);
    chk("both_reissue_lat", 64'(lat), 64'd0);
    chk("both_retry2", 64'(burst_retry_cnt), 64'd2);
    chk("both_no_done", 64'(done_cnt), 64'd3);
    respond(1'b1, 1'b0);
    chk("wd_done", 64'(burst_done), 64'd1);

    // Reset in the middle of WAIT, then a fresh 16-byte burst.
    req_burst(8'd39, 2'd2, 20'h55555);
    wait_issue(lat);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_clear", 64'(all_outs()), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_no_pulse_done", 64'(done_cnt), 64'd4);
    chk("rst_no_pulse_fail", 64'(fail_cnt), 64'd1);
    base  = issue_cnt;
    rst_n = 1'b1;
    req_burst(8'd15, 2'd3, 20'h0BEEF);
    wait_issue(lat);
    chk("post_rst_lat", 64'(lat), 64'd1);
    chk("post_rst_len", 64'(de_mux_i2c_len), 64'd15);
    chk("post_rst_addr", 64'(de_mux_i2c_address), 64'h0BEEF);
    respond(1'b1, 1'b0);
    chk("post_rst_done", 64'(burst_done), 64'd1);
    chk("post_rst_issues", 64'(issue_cnt - base), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
